mmio_uart_tx: RTL

Memory-mapped UART transmitter that sits on the CPU data bus as a responder, alongside the main memory block. It decodes stores and loads from the core's initiator-side bus (write_mem, funct3, address, write data, read data). Stored bytes are buffered in a small FIFO and serialised on a TX pin as 8N1 frames. Loads return status and control registers with the same one-cycle registered read latency as main memory, so top-level logic can mux read_data on read_hit.

---
 rtl/mmio_uart_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : bus-mapped 8N1 UART transmitter, TX FIFO, 1-cycle reg reads
// Optional even parity bit when UART_TX_PARITY_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFE0,
    parameter int          BAUD_DIV   = 104,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic PAR_FLAG = 1'b0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_n;
    logic [BAUD_W-1:0]   baud, baud_n;
    logic [2:0]          idx, idx_n;
    logic [7:0]          shreg, shreg_n;
    logic                tx_n;
    logic                tick;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic                enable;

    logic                wr_hit, rd_hit;
    logic [1:0]          wr_off;
    logic                push_req, push, pop, ovf_set, w1c;
    logic                busy, full, empty;
    logic [31:0]         status_word, rd_word, rd_fmt;

    // Address bits below the word lane and the upper store lanes have no meaning here.
    logic unused_bits;
    assign unused_bits = ^{write_data[31:8], write_address[1:0], read_address[1:0]};

    assign wr_hit   = write_mem && (write_address[31:4] == BASE_ADDR[31:4]);
    assign wr_off   = write_address[3:2];
    assign push_req = wr_hit && (wr_off == 2'd0);
    assign w1c      = wr_hit && (wr_off == 2'd1) && write_data[3];

    assign busy  = (state != IDLE);
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && enable && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && !push;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A fresh overflow wins over a clear in the same cycle.
            if (ovf_set)
                overflow <= 1'b1;
            else if (w1c)
                overflow <= 1'b0;
            if (wr_hit && (wr_off == 2'd2))
                enable <= write_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            baud  <= baud_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
        end
    end

    always_comb begin
        tick    = (baud == BAUD_LAST);
        state_n = state;
        baud_n  = baud;
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = 1'b1;
        if (state != IDLE)
            baud_n = tick ? '0 : baud + BAUD_W'(1);
        case (state)
            IDLE: begin
                if (pop) begin
                    state_n = START;
                    shreg_n = mem[rd_ptr];
                    baud_n  = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick)
                    state_n = STOP;
            end
`endif
            STOP: begin
                if (tick)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // The pin is registered from the next state so it never glitches.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[idx_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = ^shreg_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    assign rd_hit      = (read_address[31:4] == BASE_ADDR[31:4]);
    assign status_word = {16'b0, 8'(count), 3'b0, PAR_FLAG, overflow, busy, empty, full};

    always_comb begin
        rd_word = '0;
        case (read_address[3:2])
            2'd1:    rd_word = status_word;
            2'd2:    rd_word = {31'b0, enable};
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        rd_fmt = rd_word;
        case (funct3)
            3'b000:  rd_fmt = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  rd_fmt = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b100:  rd_fmt = {24'b0, rd_word[7:0]};
            3'b101:  rd_fmt = {16'b0, rd_word[15:0]};
            default: rd_fmt = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
            read_hit  <= 1'b0;
        end else begin
            read_hit  <= rd_hit;
            read_data <= rd_hit ? rd_fmt : 32'b0;
        end
    end

endmodule

`default_nettype wire
